hazard_fwd_ctrl: RTL and testbench
==================================

Name: hazard_fwd_ctrl

Overview:
- Hazard and forwarding controller for the 5-stage MIPS pipeline.
- Keeps shadow copies of the write-register and Tnew fields for the E, M and W stages.
- Drives the 2-bit select of every operand-forwarding MUX32 (00=A, 01=B, 10=C) and the global stall.
- Optionally tracks multiply/divide unit occupancy and stalls MD-dependent instructions.

Parameters:
- REG_AW, 5, register address width.
- TW, 2, width of Tuse/Tnew fields.
- MULT_CYCLES, 5, busy cycles after a mult/multu enters E.
- DIV_CYCLES, 10, busy cycles after a div/divu enters E.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- d_rs  in  REG_AW  D-stage rs address.
- d_rt  in  REG_AW  D-stage rt address.
- d_tuse_rs  in  TW  cycles until D instruction needs rs (3 = unused).
- d_tuse_rt  in  TW  cycles until D instruction needs rt (3 = unused).
- d_a3  in  REG_AW  D-stage destination register (0 = none).
- d_tnew  in  TW  cycles after E entry until the result exists.
- d_md_start  in  1  D instruction is mult/multu/div/divu.
- d_md_div  in  1  with d_md_start: instruction is a divide.
- d_md_use  in  1  D instruction is mfhi/mflo/mthi/mtlo/mult/div.
- stall  out  1  freeze PC and F/D; insert bubble into E.
- fwd_d_rs  out  2  D-stage rs mux select: 00 GRF, 01 E value, 10 M value.
- fwd_d_rt  out  2  D-stage rt mux select: 00 GRF, 01 E value, 10 M value.
- fwd_e_rs  out  2  ALU A mux select: 00 E register, 01 M value, 10 W value.
- fwd_e_rt  out  2  ALU B mux select: 00 E register, 01 M value, 10 W value.
- fwd_m_rt  out  2  store-data mux select: 00 M register, 01 W value.
- md_busy  out  1  MD unit occupied.

Behaviour:
- Asynchronous reset: all shadow registers (E/M/W a3, tnew, rs, rt; E md flags; MD counter) clear to 0.
  - With cleared state, stall=0, md_busy=0 and all selects 00.
  - Reset asserted mid-operation drops any MD busy immediately.
- Shadow advance on each rising clk edge:
  - M <= E and W <= M; tnew saturates-decrements by 1 (0 stays 0).
  - If stall=0: E <= D fields (rs, rt, a3, tnew, md flags).
  - If stall=1: E <= bubble (all zero).
- All outputs are combinational from the registered state and current D inputs (zero-latency decision).
- Register 0 is never a forwarding or stall source.
- Stall condition for rs (rt symmetric):
  - rs==E.a3 and E.tnew > d_tuse_rs, or
  - rs==M.a3 and M.tnew > d_tuse_rs.
  - An unused operand (tuse=3) never stalls.
- D-stage select priority:
  - E match with E.tnew==0 gives 01;
  - else M match with M.tnew==0 gives 10;
  - else 00 (the W stage is covered by GRF write-through).
- E-stage select priority: M match with M.tnew==0 gives 01; else W match gives 10; else 00.
- M-stage store data: W match gives 01; else 00.
- Selects may be non-00 while stall=1; the consumer ignores them.
- Simultaneous E and M matches on the same register: the younger (E) result takes precedence, including for stall.

Optional Feature:
- Macro HAZ_MD_EN.
- Defined:
  - On an edge where E holds md_start, a 4-bit counter loads DIV_CYCLES or MULT_CYCLES.
  - It decrements to 0 on later edges.
  - md_busy = (counter!=0) | E.md_start.
  - Stall additionally asserts when d_md_use & md_busy.
  - A new start in E while busy reloads the counter; this cannot occur when stalls are honoured.
- Undefined: the counter is absent, md_busy is tied 0, and d_md_* are ignored.

Decomposition:
- Shared package pipe_pkg holds:
  - forwarding select constants FWD_SRC0=2'b00, FWD_SRC1=2'b01, FWD_SRC2=2'b10;
  - TUSE_NONE=2'd3;
  - a stage_info struct {rs, rt, a3, tnew}.
- One natural sub-module, md_busy_cnt, holds the counter and busy logic and is instantiated only under HAZ_MD_EN.

Test Plan:
- lw $8 (a3=8, tnew=2) then add using rs=8 (tuse=1) -> stall=1 for exactly 1 cycle, then fwd_e_rs=10 the next cycle.
- jal (a3=31, tnew=0) then jr $31 (tuse=0) -> stall=0, fwd_d_rs=01.
- addu $3 then addu $3 again, then sub using $3 at E -> fwd_e_rs=01 (M wins over W).
- Instruction writing $0 followed by a reader of $0 (tuse=0) -> stall=0, all selects 00.
- HAZ_MD_EN: div then mflo the next cycle -> stall held for 11 cycles (E start plus 10 busy), md_busy falls, and mflo proceeds.
- reset_n low mid-div -> md_busy=0, stall=0, selects 00 asynchronously; normal operation resumes after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants, stage shadow type and helpers for the hazard/forwarding controller
package pipe_pkg;

  localparam int PIPE_AW = 5;
  localparam int PIPE_TW = 2;

  localparam logic [1:0] FWD_SRC0 = 2'b00;
  localparam logic [1:0] FWD_SRC1 = 2'b01;
  localparam logic [1:0] FWD_SRC2 = 2'b10;

  localparam logic [PIPE_TW-1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [PIPE_AW-1:0] rs;
    logic [PIPE_AW-1:0] rt;
    logic [PIPE_AW-1:0] a3;
    logic [PIPE_TW-1:0] tnew;
  } stage_info_t;

  // One stage further down the pipe: the result is one cycle closer to existing.
  function automatic stage_info_t stage_age(input stage_info_t s);
    stage_info_t r;
    r = s;
    if (s.tnew != '0) r.tnew = s.tnew - PIPE_TW'(1);
    return r;
  endfunction

  function automatic logic reg_hit(input logic [PIPE_AW-1:0] src, input logic [PIPE_AW-1:0] dst);
    return (dst != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/md_busy_cnt.sv
// rtl/md_busy_cnt.sv - multiply/divide unit occupancy counter, instantiated only when HAZ_MD_EN is defined
module md_busy_cnt #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic md_start_i,
  input  logic md_div_i,
  output logic md_busy_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (md_start_i) begin
      cnt_d = md_div_i ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The start itself already occupies the unit during its E cycle.
  assign md_busy_o = (cnt_q != 4'd0) | md_start_i;

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - 5-stage pipeline stall and forwarding-select controller; HAZ_MD_EN enables MD busy stalls
module hazard_fwd_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int TW          = 2,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [TW-1:0]     d_tuse_rs,
  input  logic [TW-1:0]     d_tuse_rt,
  input  logic [REG_AW-1:0] d_a3,
  input  logic [TW-1:0]     d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [1:0]        fwd_d_rs,
  output logic [1:0]        fwd_d_rt,
  output logic [1:0]        fwd_e_rs,
  output logic [1:0]        fwd_e_rt,
  output logic [1:0]        fwd_m_rt,
  output logic              md_busy
);

  stage_info_t e_q, m_q, w_q, d_info, e_d;
  logic        e_md_start_q, e_md_div_q, e_md_start_d, e_md_div_d;
  logic        stall_rs, stall_rt, md_busy_w;
  logic        unused_bits;

  // The youngest matching producer decides; an older one behind it is never consulted.
  function automatic logic op_stall(input logic [PIPE_AW-1:0] src, input logic [PIPE_TW-1:0] tuse,
                                    input stage_info_t e, input stage_info_t m);
    if (tuse == TUSE_NONE) return 1'b0;
    if (reg_hit(src, e.a3)) return e.tnew > tuse;
    if (reg_hit(src, m.a3)) return m.tnew > tuse;
    return 1'b0;
  endfunction

  function automatic logic [1:0] d_sel(input logic [PIPE_AW-1:0] src, input stage_info_t e,
                                       input stage_info_t m);
    if (reg_hit(src, e.a3)) return (e.tnew == '0) ? FWD_SRC1 : FWD_SRC0;
    if (reg_hit(src, m.a3)) return (m.tnew == '0) ? FWD_SRC2 : FWD_SRC0;
    return FWD_SRC0;
  endfunction

  function automatic logic [1:0] e_sel(input logic [PIPE_AW-1:0] src, input stage_info_t m,
                                       input stage_info_t w);
    if (reg_hit(src, m.a3) && (m.tnew == '0)) return FWD_SRC1;
    if (reg_hit(src, w.a3)) return FWD_SRC2;
    return FWD_SRC0;
  endfunction

  assign d_info = '{rs: d_rs, rt: d_rt, a3: d_a3, tnew: d_tnew};

  assign stall_rs = op_stall(d_rs, d_tuse_rs, e_q, m_q);
  assign stall_rt = op_stall(d_rt, d_tuse_rt, e_q, m_q);
  assign stall    = stall_rs | stall_rt | (d_md_use & md_busy_w);

  assign fwd_d_rs = d_sel(d_rs, e_q, m_q);
  assign fwd_d_rt = d_sel(d_rt, e_q, m_q);
  assign fwd_e_rs = e_sel(e_q.rs, m_q, w_q);
  assign fwd_e_rt = e_sel(e_q.rt, m_q, w_q);
  assign fwd_m_rt = reg_hit(m_q.rt, w_q.a3) ? FWD_SRC1 : FWD_SRC0;
  assign md_busy  = md_busy_w;

  assign e_d          = stall ? '0 : d_info;
  assign e_md_start_d = ~stall & d_md_start;
  assign e_md_div_d   = ~stall & d_md_div;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_q          <= '0;
      m_q          <= '0;
      w_q          <= '0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
    end else begin
      e_q          <= e_d;
      m_q          <= stage_age(e_q);
      w_q          <= stage_age(m_q);
      e_md_start_q <= e_md_start_d;
      e_md_div_q   <= e_md_div_d;
    end
  end

`ifdef HAZ_MD_EN
  md_busy_cnt #(
    .MULT_CYCLES(MULT_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_busy_cnt (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .md_start_i(e_md_start_q),
    .md_div_i  (e_md_div_q),
    .md_busy_o (md_busy_w)
  );
  assign unused_bits = ^{m_q.rs, w_q.rs, w_q.rt, w_q.tnew};
`else
  assign md_busy_w   = 1'b0;
  assign unused_bits = ^{m_q.rs, w_q.rs, w_q.rt, w_q.tnew, e_md_start_q, e_md_div_q};
`endif

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - self-checking bench for hazard_fwd_ctrl against an in-flight instruction model
module tb_hazard_fwd_ctrl;

`ifdef HAZ_MD_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] d_rs = '0, d_rt = '0, d_a3 = '0;
  logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
  logic       d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
  logic       stall, md_busy;
  logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_a3(d_a3), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_d_rs(fwd_d_rs), .fwd_d_rt(fwd_d_rt),
    .fwd_e_rs(fwd_e_rs), .fwd_e_rt(fwd_e_rt), .fwd_m_rt(fwd_m_rt),
    .md_busy(md_busy)
  );

  // Model: instructions in E/M/W, each remembering the cycle its result becomes available.
  typedef struct {
    bit v;
    int rs, rt, a3, rdy;
    bit mds, mdd;
  } ins_t;

  ins_t st[3];
  int   cyc = 0;
  int   md_until = -1;

  function automatic int rem(int rdy);
    return (rdy > cyc) ? rdy - cyc : 0;
  endfunction

  function automatic bit writes(int s, int r);
    return st[s].v && st[s].a3 != 0 && st[s].a3 == r;
  endfunction

  function automatic bit m_busy();
    return MD_EN && ((st[0].v && st[0].mds) || cyc <= md_until);
  endfunction

  function automatic bit op_stall(int r, int tuse);
    if (tuse == 3) return 1'b0;
    for (int s = 0; s < 2; s++)
      if (writes(s, r)) return rem(st[s].rdy) > tuse;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return op_stall(int'(d_rs), int'(d_tuse_rs)) || op_stall(int'(d_rt), int'(d_tuse_rt)) ||
           (d_md_use && m_busy());
  endfunction

  function automatic int sel_d(int r);
    for (int s = 0; s < 2; s++)
      if (writes(s, r)) return (rem(st[s].rdy) == 0) ? s + 1 : 0;
    return 0;
  endfunction

  function automatic int sel_e(int r);
    if (writes(1, r) && rem(st[1].rdy) == 0) return 1;
    if (writes(2, r)) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    ins_t n;
    bit   stl;
    if (!reset_n) begin
      for (int s = 0; s < 3; s++) st[s] = '{default: 0};
      md_until = -1;
    end else begin
      stl = m_stall();
      if (st[0].v && st[0].mds) md_until = cyc + (st[0].mdd ? DIV_N : MULT_N);
      st[2] = st[1];
      st[1] = st[0];
      n = '{default: 0};
      if (!stl) begin
        n.v   = 1'b1;
        n.rs  = int'(d_rs);
        n.rt  = int'(d_rt);
        n.a3  = int'(d_a3);
        n.rdy = cyc + 1 + int'(d_tnew);
        n.mds = d_md_start;
        n.mdd = d_md_div;
      end
      st[0] = n;
      cyc++;
    end
  end

  // Literal expectations from the stimulus; -1 means none for this cycle.
  int pin_stall = -1, pin_dr = -1, pin_er = -1, pin_et = -1, pin_mr = -1, pin_md = -1;
  bit pin_z = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(string nm, int act, int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("stall", int'(stall), int'(m_stall()));
    chk("fwd_d_rs", int'(fwd_d_rs), sel_d(int'(d_rs)));
    chk("fwd_d_rt", int'(fwd_d_rt), sel_d(int'(d_rt)));
    chk("fwd_e_rs", int'(fwd_e_rs), sel_e(st[0].v ? st[0].rs : 0));
    chk("fwd_e_rt", int'(fwd_e_rt), sel_e(st[0].v ? st[0].rt : 0));
    chk("fwd_m_rt", int'(fwd_m_rt), (st[1].v && writes(2, st[1].rt)) ? 1 : 0);
    chk("md_busy", int'(md_busy), int'(m_busy()));
    if (pin_stall >= 0) begin
      chk("pin_stall", int'(stall), pin_stall);
      chk("pin_model_stall", int'(m_stall()), pin_stall);
    end
    if (pin_dr >= 0) chk("pin_fwd_d_rs", int'(fwd_d_rs), pin_dr);
    if (pin_er >= 0) chk("pin_fwd_e_rs", int'(fwd_e_rs), pin_er);
    if (pin_et >= 0) chk("pin_fwd_e_rt", int'(fwd_e_rt), pin_et);
    if (pin_mr >= 0) chk("pin_fwd_m_rt", int'(fwd_m_rt), pin_mr);
    if (pin_md >= 0) chk("pin_md_busy", int'(md_busy), pin_md);
    if (pin_z) chk("pin_all_sel_zero", int'({fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt}), 0);
  end

  task automatic cyc_step();
    @(posedge clk);
    #1;
    pin_stall = -1; pin_dr = -1; pin_er = -1; pin_et = -1; pin_mr = -1; pin_md = -1;
    pin_z = 1'b0;
  endtask

  task automatic drv(int rs, int tr, int rt, int tt, int a3, int tn,
                     bit ms = 1'b0, bit md = 1'b0, bit mu = 1'b0);
    d_rs = 5'(rs); d_tuse_rs = 2'(tr);
    d_rt = 5'(rt); d_tuse_rt = 2'(tt);
    d_a3 = 5'(a3); d_tnew = 2'(tn);
    d_md_start = ms; d_md_div = md; d_md_use = mu;
  endtask

  task automatic nops(int n);
    drv(0, 3, 0, 3, 0, 0);
    repeat (n) cyc_step();
  endtask

  task automatic lw_add_seq();
    drv(29, 1, 0, 3, 8, 2); cyc_step();
    drv(8, 1, 9, 1, 10, 1); pin_stall = 1; pin_dr = 0; cyc_step();
    pin_stall = 0; cyc_step();
    drv(0, 3, 0, 3, 0, 0); pin_er = 2; cyc_step();
    nops(3);
  endtask

  initial begin
    pin_z = 1'b1; pin_stall = 0; pin_md = 0;
    @(negedge clk);
    pin_z = 1'b1; pin_stall = 0; pin_md = 0;
    @(negedge clk);
    #3 reset_n = 1'b1;
    cyc_step();

    lw_add_seq();

    drv(0, 3, 0, 3, 31, 0); cyc_step();
    drv(31, 0, 0, 3, 0, 0); pin_stall = 0; pin_dr = 1; cyc_step();
    nops(3);

    drv(1, 1, 2, 1, 3, 1); cyc_step();
    drv(1, 1, 2, 1, 3, 1); cyc_step();
    drv(3, 1, 0, 3, 4, 1); pin_stall = 0; pin_dr = 0; cyc_step();
    drv(0, 3, 0, 3, 0, 0); pin_er = 1; cyc_step();
    nops(3);

    drv(0, 3, 0, 3, 0, 2); cyc_step();
    drv(0, 0, 0, 0, 5, 0); pin_stall = 0; pin_z = 1'b1; cyc_step();
    drv(0, 3, 0, 3, 0, 0); pin_z = 1'b1; cyc_step();
    nops(3);

    drv(1, 1, 2, 1, 5, 1); cyc_step();
    drv(6, 1, 5, 2, 0, 0); pin_stall = 0; cyc_step();
    drv(0, 3, 0, 3, 0, 0); pin_et = 1; cyc_step();
    pin_mr = 1; cyc_step();
    nops(2);

    drv(4, 1, 5, 1, 0, 0, 1'b1, 1'b1, 1'b1); pin_stall = 0; pin_md = 0; cyc_step();
    drv(0, 3, 0, 3, 2, 1, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k <= DIV_N; k++) begin
      pin_stall = int'(MD_EN); pin_md = int'(MD_EN);
      cyc_step();
    end
    pin_stall = 0; pin_md = 0; cyc_step();
    drv(0, 3, 0, 3, 0, 0); pin_stall = 0; cyc_step();
    nops(3);

    drv(4, 1, 5, 1, 0, 0, 1'b1, 1'b1, 1'b1); cyc_step();
    drv(0, 3, 0, 3, 2, 1, 1'b0, 1'b0, 1'b1); pin_md = int'(MD_EN); pin_stall = int'(MD_EN); cyc_step();
    pin_md = int'(MD_EN); pin_stall = int'(MD_EN);
    #2 reset_n = 1'b0;
    pin_md = 0; pin_stall = 0; pin_z = 1'b1;
    cyc_step();
    pin_md = 0; pin_stall = 0; pin_z = 1'b1;
    #2 reset_n = 1'b1;
    cyc_step();
    nops(2);

    lw_add_seq();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
